// File: rtl/booth_mul_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : booth_pkg
//  Brief    : Shared state encoding, default width and ID-width helper for
//             the Booth multiplier scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

    localparam int c_def_width = 16;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_start = 2'd1;
    localparam state_t c_st_wait  = 2'd2;
    localparam state_t c_st_resp  = 2'd3;

    // Requester index width; a single requester still needs one bit.
    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_mul_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mul_scheduler_if
//  Brief    : Client-side request and response channels of the scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
interface booth_mul_scheduler_if
    import booth_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = c_def_width
);
    localparam int c_idw = idw_of(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [c_idw-1:0]      rsp_id;
    logic [2*WIDTH-1:0]    rsp_prod;
    logic                  rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/booth_mul_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin picker; searches from ptr+1 upward.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import booth_pkg::*;
#(
    parameter  int NREQ  = 4,
    localparam int c_idw = idw_of(NREQ)
)(
    input  wire logic [NREQ-1:0]  req,
    input  wire logic [c_idw-1:0] ptr,
    output logic      [NREQ-1:0]  gnt,
    output logic      [c_idw-1:0] gnt_idx
);

    logic [c_idw-1:0] w_idx;
    logic             w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = c_idw'((int'(ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/booth_mul_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mul_scheduler
//  Brief    : Shares one sequential Booth multiplier among NREQ clients with
//             round-robin grant, one-cycle start pulse and a hang watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module booth_mul_scheduler
    import booth_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = c_def_width,
    parameter int TIMEOUT = 64
)(
    input  wire logic               clk,
    input  wire logic               rst_n,
    booth_mul_scheduler_if.slave    bus,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  wire logic               mul_done,
    input  wire logic [2*WIDTH-1:0] mul_prod,
    output logic                    busy
);

    localparam int c_idw = idw_of(NREQ);
    localparam int c_cw  = $clog2(TIMEOUT + 1);

    state_t             r_state;
    logic [c_idw-1:0]   r_rr_ptr;
    logic [c_cw-1:0]    r_cnt;
    logic               r_armed;
    logic               r_mul_start;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic               r_rsp_valid;
    logic [c_idw-1:0]   r_rsp_id;
    logic [2*WIDTH-1:0] r_rsp_prod;
    logic               r_rsp_err;

    logic [NREQ-1:0]    w_gnt;
    logic [c_idw-1:0]   w_gnt_idx;
    logic               w_can_grant;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // The multiplier has no reset: hold off grants until its done level is seen low.
    assign w_can_grant = (r_state == c_st_idle) && (r_armed || !mul_done) && (|bus.req_valid);

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt_idx == c_idw'(k)) begin
                w_sel_a = bus.req_a[k*WIDTH +: WIDTH];
                w_sel_b = bus.req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_rr_ptr    <= c_idw'(NREQ - 1);
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_prod  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_mul_start <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (!mul_done) begin
                        r_armed <= 1'b1;
                    end
                    if (w_can_grant) begin
                        r_mul_a     <= w_sel_a;
                        r_mul_b     <= w_sel_b;
                        r_rsp_id    <= w_gnt_idx;
                        r_mul_start <= 1'b1;
                        r_state     <= c_st_start;
                    end
                end
                c_st_start: begin
                    r_cnt   <= '0;
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    if (r_cnt != {c_cw{1'b1}}) begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                    if (mul_done) begin
                        r_rsp_prod  <= mul_prod;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_st_resp;
                    end else if (r_cnt == c_cw'(TIMEOUT - 1)) begin
                        r_rsp_prod  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    if (bus.rsp_ready) begin
                        r_rr_ptr    <= r_rsp_id;
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.req_ready = w_can_grant ? w_gnt : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_prod  = r_rsp_prod;
    assign bus.rsp_err   = r_rsp_err;
    assign mul_start     = r_mul_start;
    assign mul_a         = r_mul_a;
    assign mul_b         = r_mul_b;
    assign busy          = (r_state != c_st_idle);

endmodule
`default_nettype wire
